mem_bus_responder: RTL and testbench

- Memory-bus target that serves the V188 CPU's memory strobes (address, write data, read strobe, write strobe) and returns read data plus a ready handshake.
- Backed by a byte-wide synchronous RAM mapped at a fixed base address window, with a programmable wait-state count.
- Sits between the CPU wrapper's memory bus and on-chip RAM in the simulation and FPGA top levels.

---
 rtl/mem_bus_pkg.sv | 25 ++
 rtl/mem_bus_responder_if.sv | 31 +++
 rtl/mem_bus_responder_ram.sv | 29 ++
 rtl/mem_bus_responder.sv | 138 +++++++++++++
 tb/tb_mem_bus_responder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_pkg
// Brief    : Shared types and constants for the CPU memory-bus responder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

  // Bus geometry of the CPU memory interface.
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 8;

  // Read data returned for an access outside the decoded window.
  localparam logic [DATA_W-1:0] MISS_DATA = 8'hFF;

  // Transfer sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_responder_if
// Brief    : CPU memory strobe bus (address, data, strobes, ready, status).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_bus_responder_if;

  logic [mem_bus_pkg::ADDR_W-1:0] addr;
  logic [mem_bus_pkg::DATA_W-1:0] wdata;
  logic [mem_bus_pkg::DATA_W-1:0] rdata;
  logic                           rd;
  logic                           wr;
  logic                           ready;
  logic                           hit;
  logic                           proto_err;

  // CPU side drives address, data and strobes.
  modport master (
    output addr, wdata, rd, wr,
    input  rdata, ready, hit, proto_err
  );

  // Memory target side answers with data and status.
  modport slave (
    input  addr, wdata, rd, wr,
    output rdata, ready, hit, proto_err
  );

endinterface
`default_nettype wire

// File: rtl/mem_bus_responder_ram.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_responder_ram
// Brief    : Single-port 2^AW x 8 RAM with one-cycle registered read.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_responder_ram #(
  parameter int unsigned AW        = 16,
  parameter string       INIT_FILE = ""
) (
  input  wire logic          clk,
  input  wire logic          we,
  input  wire logic [AW-1:0] addr,
  input  wire logic [7:0]    wdata,
  output logic      [7:0]    q
);

  logic [7:0] mem [0:(2**AW)-1];

  // Registered read returns the old contents when written in the same cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_responder
// Brief    : CPU memory-bus target: window decode, wait states, ready pulse,
//            sticky protocol-error flag, backed by an on-chip byte RAM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE        = 20'h00000,
  parameter int unsigned       AW          = 16,
  parameter int unsigned       WAIT_STATES = 2,
  parameter string             INIT_FILE   = ""
) (
  input wire logic            clk,
  input wire logic            rst,
  mem_bus_responder_if.slave  bus
);

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt;
  logic [AW-1:0]       lat_offs;
  logic [DATA_W-1:0]   lat_data;
  logic                lat_wr;
  logic                lat_hit;
  logic                hit_r;
  logic                perr_r;

  logic [ADDR_W-1:0]   offs_now;
  logic                hit_now;
  logic                strobe;
  logic                commit;
  logic [AW-1:0]       ram_addr;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_q;

  // Window decode: the unsigned subtract makes addresses below BASE wrap high.
  always_comb begin
    offs_now = bus.addr - BASE;
    hit_now  = ((offs_now >> AW) == '0);
    strobe   = bus.rd | bus.wr;
  end

  // Next-state logic; a strobe dropping before ACK abandons the transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (strobe) state_nxt = WAIT;
      WAIT: begin
        if (!strobe) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = ACK;
        end
      end
      ACK:  state_nxt = HOLD;
      HOLD: if (!bus.rd && !bus.wr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // RAM is addressed straight from the bus in IDLE so read data is ready
  // after one cycle; later it follows the latched offset.
  always_comb begin
    commit   = (state == WAIT) && (state_nxt == ACK);
    ram_addr = (state == IDLE) ? offs_now[AW-1:0] : lat_offs;
    ram_we   = commit && lat_wr && lat_hit;
  end

  // Access latch, wait counter, hit status and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 4'd0;
      lat_offs <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
      lat_hit  <= 1'b0;
      hit_r    <= 1'b0;
      perr_r   <= 1'b0;
    end else begin
      if (state == IDLE && strobe) begin
        lat_offs <= offs_now[AW-1:0];
        lat_data <= bus.wdata;
        lat_wr   <= bus.wr;
        lat_hit  <= hit_now;
        cnt      <= 4'(WAIT_STATES);
        if (bus.rd && bus.wr) begin
          perr_r <= 1'b1;
        end
      end
      if (state == WAIT) begin
        if (!strobe) begin
          perr_r <= 1'b1;
        end else if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end
      end
      if (commit) begin
        hit_r <= lat_hit;
      end
    end
  end

  mem_bus_responder_ram #(
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (lat_data),
    .q     (ram_q)
  );

  // Bus outputs: data is only meaningful during the ready pulse.
  always_comb begin
    bus.ready     = (state == ACK);
    bus.rdata     = '0;
    if (state == ACK && !lat_wr) begin
      bus.rdata = lat_hit ? ram_q : MISS_DATA;
    end
    bus.hit       = hit_r;
    bus.proto_err = perr_r;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_responder
// Brief    : Scoreboard bench; several responder instances with different
//            BASE / WAIT_STATES share one stimulus bus, one is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_responder;
  import mem_bus_pkg::*;

  localparam int N = 6;
  localparam int          WS_T   [N] = '{2, 2, 0, 5, 1, 15};
  localparam logic [19:0] BASE_T [N] = '{20'h00000, 20'h80000, 20'h00000,
                                         20'h00000, 20'h00000, 20'h00000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;

  logic [7:0]   rdata_v [N];
  logic [N-1:0] ready_v;
  logic [N-1:0] hit_v;
  logic [N-1:0] perr_v;

  logic [2:0] sel = 3'd0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic       prev_ready = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       hit;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] model [int];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < N; k++) begin : g_dut
    mem_bus_responder_if bif ();
    assign bif.addr   = addr;
    assign bif.wdata  = wdata;
    assign bif.rd     = rd;
    assign bif.wr     = wr;
    assign rdata_v[k] = bif.rdata;
    assign ready_v[k] = bif.ready;
    assign hit_v[k]   = bif.hit;
    assign perr_v[k]  = bif.proto_err;

    mem_bus_responder #(
      .BASE        (BASE_T[k]),
      .AW          (16),
      .WAIT_STATES (WS_T[k]),
      .INIT_FILE   ("")
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ready pulse of the observed instance must match the head
  // of the scoreboard in data, hit and cycle, and last exactly one cycle.
  always @(negedge clk) begin
    if (ready_v[sel]) begin
      exp_t e;
      chk("ready_width", 32'(prev_ready), 32'd0);
      chk("ready_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rdata", 32'(rdata_v[sel]), 32'(e.data));
        chk("hit", 32'(hit_v[sel]), 32'(e.hit));
        chk("latency", 32'(cyc), 32'(e.at));
      end
    end
    prev_ready = ready_v[sel];
  end

  task automatic access(input logic w, input logic r, input logic [19:0] a,
                        input logic [7:0] d, input logic [7:0] ed, input logic eh);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    addr = a; wdata = d; wr = w; rd = r;
    exp_q.push_back('{data: ed, hit: eh, at: cyc + 2 + WS_T[sel]});
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (ready_v[sel]) got = 1'b1;
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic wr_acc(input logic [19:0] a, input logic [7:0] d, input logic eh);
    access(1'b1, 1'b0, a, d, 8'h00, eh);
  endtask

  task automatic rd_acc(input logic [19:0] a, input logic [7:0] ed, input logic eh);
    access(1'b0, 1'b1, a, 8'h00, ed, eh);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [19:0] a, ra;
    logic [7:0]  d;
    int          segs [3];
    segs = '{2, 4, 5};

    // Reset state.
    sel = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(ready_v[0]), 32'd0);
    chk("reset_rdata", 32'(rdata_v[0]), 32'd0);
    chk("reset_hit",   32'(hit_v[0]),   32'd0);
    chk("reset_perr",  32'(perr_v[0]),  32'd0);

    // Write then read back, BASE=0, WAIT_STATES=2.
    wr_acc(20'h00123, 8'hA5, 1'b1);
    rd_acc(20'h00123, 8'hA5, 1'b1);
    @(negedge clk);
    chk("perr_clean", 32'(perr_v[0]), 32'd0);

    // Write strobe dropped in WAIT: abandoned, no write, flag set.
    wr_acc(20'h00020, 8'h00, 1'b1);
    @(posedge clk); #1 addr = 20'h00020; wdata = 8'h99; wr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 wr = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("perr_abandon", 32'(perr_v[0]), 32'd1);
    rd_acc(20'h00020, 8'h00, 1'b1);

    // Reset clears the sticky flag and the hit status but not the RAM.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("perr_cleared", 32'(perr_v[0]), 32'd0);
    chk("hit_cleared",  32'(hit_v[0]),  32'd0);

    // Both strobes high: treated as a write, flag set and sticky.
    access(1'b1, 1'b1, 20'h00010, 8'h77, 8'h00, 1'b1);
    chk("perr_both", 32'(perr_v[0]), 32'd1);
    rd_acc(20'h00010, 8'h77, 1'b1);
    chk("perr_sticky", 32'(perr_v[0]), 32'd1);

    // Window decode with BASE=0x80000: misses, edges, no aliasing.
    sel = 3'd1;
    wr_acc(20'h80000, 8'h3C, 1'b1);
    wr_acc(20'h8FFFF, 8'h5A, 1'b1);
    rd_acc(20'h90000, 8'hFF, 1'b0);
    wr_acc(20'h90000, 8'h11, 1'b0);
    rd_acc(20'h80000, 8'h3C, 1'b1);
    rd_acc(20'h7FFFF, 8'hFF, 1'b0);
    rd_acc(20'h8FFFF, 8'h5A, 1'b1);

    // Read strobe held 12 cycles with WAIT_STATES=0: one pulse only.
    sel = 3'd2;
    wr_acc(20'h00300, 8'h6B, 1'b1);
    @(posedge clk); #1 addr = 20'h00300; rd = 1'b1;
    exp_q.push_back('{data: 8'h6B, hit: 1'b1, at: cyc + 2});
    repeat (12) @(posedge clk);
    #1 rd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("held_one_pulse", 32'(exp_q.size()), 32'd0);
    rd_acc(20'h00300, 8'h6B, 1'b1);

    // Reset in the middle of a WAIT_STATES=5 write: nothing committed.
    sel = 3'd3;
    wr_acc(20'h00040, 8'h12, 1'b1);
    @(posedge clk); #1 addr = 20'h00040; wdata = 8'hEE; wr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; wr = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_perr", 32'(perr_v[3]), 32'd0);
    rd_acc(20'h00040, 8'h12, 1'b1);

    // Back-to-back write/read pairs; each read targets the previous pair's
    // address so a broken address path cannot hide.
    foreach (segs[s]) begin
      sel = 3'(segs[s]);
      model.delete();
      ra = '0;
      for (int i = 0; i < 86; i++) begin
        a = 20'($urandom_range(0, 16'hFFFF));
        d = 8'($urandom_range(0, 255));
        wr_acc(a, d, 1'b1);
        model[int'(a)] = d;
        if (i == 0) ra = a;
        rd_acc(ra, model[int'(ra)], 1'b1);
        ra = a;
      end
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
